// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: two-read / two-write register file with write-through
// bypass, optional hardwired zero register and per-register busy scoreboard.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset (clears data and busy bits)
//   A1/A2          read addresses       RD1/RD2  read data (bypassed)
//   V1/V2          operand valid (not busy, or satisfied by a same-cycle write)
//   A3/WD3/WE3     write lane 0         A4/WD4/WE4  write lane 1 (wins ties)
//   RA/RE          reserve destination (sets busy)
//   CLR            synchronous flush of all busy bits
module regfile_bypass_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              V1,
    output logic              V2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A4,
    input  logic [DATA_W-1:0] WD4,
    input  logic              WE4,
    input  logic [ADDR_W-1:0] RA,
    input  logic              RE,
    input  logic              CLR
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic ZR  = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Effective enables: with a hardwired zero register, any write or
    // reserve aimed at address 0 is dropped so entry 0 stays zero / idle.
    logic we3_ok;
    logic we4_ok;
    logic re_ok;

    always_comb begin
        we3_ok = WE3 && !(ZR && (A3 == '0));
        we4_ok = WE4 && !(ZR && (A4 == '0));
        re_ok  = RE  && !(ZR && (RA == '0));
    end

    // Register array: lane 1 has priority when both lanes hit one entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (we4_ok && (A4 == ADDR_W'(k))) begin
                    mem[k] <= WD4;
                end else if (we3_ok && (A3 == ADDR_W'(k))) begin
                    mem[k] <= WD3;
                end
            end
        end
    end

    // Scoreboard: a reserve outranks a retiring write to the same entry
    // (the new producer owns it), and both outrank the global flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (re_ok && (RA == ADDR_W'(k))) begin
                    busy[k] <= 1'b1;
                end else if ((we3_ok && (A3 == ADDR_W'(k))) ||
                             (we4_ok && (A4 == ADDR_W'(k)))) begin
                    busy[k] <= 1'b0;
                end else if (CLR) begin
                    busy[k] <= 1'b0;
                end
            end
        end
    end

    // Read port 1
    logic z1;
    logic h31;
    logic h41;

    always_comb begin
        z1  = ZR && (A1 == '0);
        h31 = WE3 && (A3 == A1);
        h41 = WE4 && (A4 == A1);
        RD1 = mem[A1];
        V1  = !busy[A1] || h31 || h41;
        if (z1) begin
            RD1 = '0;
            V1  = 1'b1;
        end else if (h41) begin
            RD1 = WD4;
        end else if (h31) begin
            RD1 = WD3;
        end
    end

    // Read port 2
    logic z2;
    logic h32;
    logic h42;

    always_comb begin
        z2  = ZR && (A2 == '0);
        h32 = WE3 && (A3 == A2);
        h42 = WE4 && (A4 == A2);
        RD2 = mem[A2];
        V2  = !busy[A2] || h32 || h42;
        if (z2) begin
            RD2 = '0;
            V2  = 1'b1;
        end else if (h42) begin
            RD2 = WD4;
        end else if (h32) begin
            RD2 = WD3;
        end
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb_regfile_bypass_sb: directed checks of regfile_bypass_sb with
// ZERO_REG=1 (u_dut) and ZERO_REG=0 (u_dut0) driven by shared stimulus.
module tb_regfile_bypass_sb;

    logic        clk;
    logic        reset;
    logic [4:0]  A1, A2, A3, A4, RA;
    logic [31:0] WD3, WD4;
    logic        WE3, WE4, RE, CLR;

    logic [31:0] RD1, RD2, RD1z, RD2z;
    logic        V1, V2, V1z, V2z;

    int npass;
    int ntotal;

    regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
        .clk(clk), .reset(reset),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .V1(V1), .V2(V2),
        .A3(A3), .WD3(WD3), .WE3(WE3),
        .A4(A4), .WD4(WD4), .WE4(WE4),
        .RA(RA), .RE(RE), .CLR(CLR)
    );

    regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .A1(A1), .A2(A2), .RD1(RD1z), .RD2(RD2z), .V1(V1z), .V2(V2z),
        .A3(A3), .WD3(WD3), .WE3(WE3),
        .A4(A4), .WD4(WD4), .WE4(WE4),
        .RA(RA), .RE(RE), .CLR(CLR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntotal++;
        if (got === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WE3 = 1'b0;
        WE4 = 1'b0;
        RE  = 1'b0;
        CLR = 1'b0;
    endtask

    initial begin
        npass  = 0;
        ntotal = 0;
        reset  = 1'b1;
        A1 = '0; A2 = '0; A3 = '0; A4 = '0; RA = '0;
        WD3 = '0; WD4 = '0;
        idle();

        // Mid-cycle reset pulse; every entry must read zero and be valid.
        #3 reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i);
            #1;
            check("reset_rd1", RD1, 32'd0);
        end
        check("reset_v1", {31'd0, V1}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;

        // Single write to register 10, then sweep.
        A3 = 5'd10; WD3 = 32'd31; WE3 = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i);
            #1;
            check("sweep_rd1", RD1, (i == 10) ? 32'd31 : 32'd0);
        end

        // Both lanes to register 5: lane 1 wins through bypass and array.
        WE3 = 1'b1; WE4 = 1'b1; A3 = 5'd5; A4 = 5'd5;
        WD3 = 32'h11; WD4 = 32'h22; A1 = 5'd5;
        #1;
        check("bypass_lane1", RD1, 32'h22);
        tick();
        idle();
        #1;
        check("array_lane1", RD1, 32'h22);

        // Write and reserve to address 0.
        A3 = 5'd0; WD3 = 32'd255; WE3 = 1'b1; RE = 1'b1; RA = 5'd0;
        A2 = 5'd0;
        #1;
        check("zr1_rd2_byp", RD2, 32'd0);
        check("zr1_v2_byp", {31'd0, V2}, 32'd1);
        check("zr0_rd2_byp", RD2z, 32'd255);
        tick();
        idle();
        #1;
        check("zr1_rd2", RD2, 32'd0);
        check("zr1_v2", {31'd0, V2}, 32'd1);
        check("zr0_rd2", RD2z, 32'd255);
        check("zr0_v2_busy", {31'd0, V2z}, 32'd0);
        // Retire register 0 in the ZERO_REG=0 copy.
        A4 = 5'd0; WD4 = 32'd255; WE4 = 1'b1;
        tick();
        idle();
        #1;
        check("zr0_v2_clr", {31'd0, V2z}, 32'd1);

        // Reserve 7, stay invalid until lane 1 retires it.
        RE = 1'b1; RA = 5'd7;
        tick();
        idle();
        A1 = 5'd7;
        #1;
        check("sb_v1_busy", {31'd0, V1}, 32'd0);
        tick();
        check("sb_v1_busy2", {31'd0, V1}, 32'd0);
        WE4 = 1'b1; A4 = 5'd7; WD4 = 32'd99;
        #1;
        check("sb_v1_byp", {31'd0, V1}, 32'd1);
        check("sb_rd1_byp", RD1, 32'd99);
        tick();
        idle();
        #1;
        check("sb_v1_after", {31'd0, V1}, 32'd1);
        check("sb_rd1_after", RD1, 32'd99);

        // Reserve and write to 3 in one cycle: stays busy, data lands.
        RE = 1'b1; RA = 5'd3; WE3 = 1'b1; A3 = 5'd3; WD3 = 32'd5;
        tick();
        idle();
        A1 = 5'd3;
        #1;
        check("re_wr_v1", {31'd0, V1}, 32'd0);
        check("re_wr_rd1", RD1, 32'd5);

        // Busy 3 and 9, then reserve 4 with flush.
        RE = 1'b1; RA = 5'd9;
        tick();
        RA = 5'd4; CLR = 1'b1;
        tick();
        idle();
        A1 = 5'd3; A2 = 5'd9;
        #1;
        check("clr_v3", {31'd0, V1}, 32'd1);
        check("clr_v9", {31'd0, V2}, 32'd1);
        A1 = 5'd4;
        #1;
        check("clr_v4", {31'd0, V1}, 32'd0);

        // Reset mid-operation with register 12 busy and being written.
        RE = 1'b1; RA = 5'd12;
        tick();
        idle();
        WE3 = 1'b1; A3 = 5'd12; WD3 = 32'd77;
        A1 = 5'd12; A2 = 5'd4;
        #1;
        check("pre_rst_byp", RD1, 32'd77);
        reset = 1'b0;
        @(posedge clk);
        #2;
        idle();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_rd12", RD1, 32'd0);
        check("rst_v12", {31'd0, V1}, 32'd1);
        check("rst_v4", {31'd0, V2}, 32'd1);
        A2 = 5'd5;
        #1;
        check("rst_rd5", RD2, 32'd0);
        tick();
        check("rst_rd12_later", RD1, 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/regfile_bypass_sb.md
# regfile_bypass_sb

Parametrised two-read/two-write register file with write-through bypass, optional hardwired-zero register 0, and a per-register busy scoreboard. It is the register bank for the dual-issue datapath: the decode stage reads operands and reserves destinations, and the two writeback lanes retire results. Each read port reports operand validity, so the issue stage can stall on pending writes.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy

Ports:
- clk  in  1  single clock, rising-edge active
- reset  in  1  asynchronous, active-low; clears all registers and busy bits
- A1, A2  in  ADDR_W  read addresses
- RD1, RD2  out  DATA_W  read data
- V1, V2  out  1  operand valid for A1 / A2
- A3, WD3, WE3  in  ADDR_W / DATA_W / 1  write lane 0: address, data, enable
- A4, WD4, WE4  in  ADDR_W / DATA_W / 1  write lane 1: address, data, enable
- RA  in  ADDR_W  reserve address (destination being issued)
- RE  in  1  reserve enable
- CLR  in  1  synchronous flush of all busy bits

## Operation
- Storage: 2^ADDR_W x DATA_W array, plus a busy[2^ADDR_W] bit vector.
- Writes: on the rising edge, WE3 writes WD3 to A3 and WE4 writes WD4 to A4.
  - If both lanes are enabled to the same address, lane 1 (WD4) wins.
- Reads are combinational, with bypass. For each port n:
  - RDn = WD4 if WE4 and A4 == An.
  - Otherwise RDn = WD3 if WE3 and A3 == An.
  - Otherwise RDn = array[An].
- ZERO_REG=1:
  - An == 0 gives RDn = 0 and Vn = 1, with no bypass.
  - Writes and reserves to address 0 are dropped.
- ZERO_REG=0: register 0 behaves like any other register.
- Busy update at each edge, in priority order (highest first):
  - RE sets busy[RA].
  - Otherwise, a write (either lane) to address k clears busy[k].
  - Otherwise, CLR clears every busy bit.
  - Consequences: RE together with a write to RA leaves busy set, because the new producer owns it. RE together with CLR leaves only busy[RA] set.
- Valid: Vn = !busy[An] OR (WE3 and A3 == An) OR (WE4 and A4 == An). A bypassed write satisfies a pending read in the same cycle.
- CLR never alters register data.

## Timing
- Reset (reset = 0): asynchronous. Immediately, all array entries = 0 and busy = 0. Outputs follow combinationally: RD1 = RD2 = 0 unless bypassed, V1 = V2 = 1.
- While reset is low, writes, reserves and CLR are ignored. Operation resumes at the first rising edge after reset goes high.
- Reset asserted mid-operation discards any write in that cycle. There is no partial update.
- Read latency: 0 cycles, combinational from An, WEx, Ax, WDx and array state.
- Write latency:
  - Visible through the bypass in the same cycle WEx is high.
  - Visible from the array from the next cycle onward.
- Busy latency:
  - A reserve at edge t makes Vn = 0 for that address from t until the edge that commits the clearing write.
  - During the clearing write's own cycle, Vn = 1 via the bypass term.
- No handshake: the issue stage must hold its stall while Vn = 0. Reserving a register that is already busy is legal; it stays busy.
- Address wrap: none. All 2^ADDR_W addresses are valid. Out-of-range addresses cannot occur, since they are not representable in ADDR_W bits.

## Test plan
- Reset and basic write/read: pulse reset low mid-cycle, then check RD1 = 0 for every address. Then write A3 = 10, WD3 = 31, WE3 = 1 for one edge, sweep A1 over 0..31, and require RD1 = 31 only at A1 = 10.
- Bypass and lane priority: in the same cycle set WE3 = WE4 = 1, A3 = A4 = 5, WD3 = 0x11, WD4 = 0x22, A1 = 5. Require RD1 = 0x22 before the edge and array[5] = 0x22 after it.
- Zero register, ZERO_REG = 1: write A3 = 0, WD3 = 255 and reserve RA = 0. Require RD2 = 0 and V2 = 1 with A2 = 0. Repeat with ZERO_REG = 0 and require RD2 = 255.
- Scoreboard: RE = 1, RA = 7 → V1 = 0 for A1 = 7 on the following cycles. When WE4 = 1, A4 = 7, WD4 = 99: V1 = 1 and RD1 = 99 in that cycle, and V1 stays 1 afterwards.
- Simultaneous events:
  - RE with RA = 3 plus a write to register 3 in the same cycle → busy[3] = 1 afterwards.
  - RE with RA = 4 plus CLR, with 3 and 9 busy → only busy[4] set afterwards.
- Reset mid-operation: assert reset during WE3 = 1, A3 = 12, WD3 = 77 with busy[12] set. Require array[12] = 0, busy = 0 and V1 = 1 for A1 = 12 after reset is released.
